// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shifter controller, applies at most MAX_STEP positions per pass
// behind a START/BUSY/DONE handshake with a registered RESULT/ZERO.
module shift_sequencer #(
   parameter int MAX_STEP = 7
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       START,
   input  logic [1:0] OPCODE,
   input  logic [7:0] DATA,
   input  logic [7:0] AMOUNT,
   output logic [7:0] RESULT,
   output logic       BUSY,
   output logic       DONE,
   output logic       ZERO
);
   typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
   state_t state_q, state_d;
   logic [7:0] acc_q, acc_d, result_q, result_d, shifted;
   logic [1:0] op_q, op_d;
   logic [3:0] rem_q, rem_d, eff, rem_left;
   logic [2:0] step;
   logic zero_q, zero_d;

   function automatic logic [7:0] shift_by(input logic [1:0] op, input logic [7:0] a, input logic [2:0] s);
      logic [15:0] rot;
      logic [7:0] sra;
      rot = {a, a} >> s;
      sra = $signed(a) >>> s;
      return op == 2'b00 ? a << s : op == 2'b01 ? a >> s : op == 2'b10 ? sra : rot[7:0];
   endfunction

   // rotates only need the low three bits; linear shifts saturate at a full clear
   assign eff = OPCODE == 2'b11 ? {1'b0, AMOUNT[2:0]} : AMOUNT > 8'd8 ? 4'd8 : AMOUNT[3:0];
   assign step = rem_q > 4'(MAX_STEP) ? 3'(MAX_STEP) : rem_q[2:0];
   assign rem_left = rem_q - {1'b0, step};
   assign shifted = shift_by(op_q, acc_q, step);

   always_comb begin
      state_d = state_q;
      acc_d = acc_q;
      op_d = op_q;
      rem_d = rem_q;
      result_d = result_q;
      zero_d = zero_q;
      case (state_q)
         IDLE: if (START) begin
            acc_d = DATA;
            op_d = OPCODE;
            rem_d = eff;
            state_d = eff == 4'd0 ? FIN : SHIFT;
            result_d = eff == 4'd0 ? DATA : result_q;
            zero_d = eff == 4'd0 ? DATA == 8'h00 : zero_q;
         end
         SHIFT: begin
            acc_d = shifted;
            rem_d = rem_left;
            state_d = rem_left == 4'd0 ? FIN : SHIFT;
            result_d = rem_left == 4'd0 ? shifted : result_q;
            zero_d = rem_left == 4'd0 ? shifted == 8'h00 : zero_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
         acc_q <= '0;
         op_q <= '0;
         rem_q <= '0;
         result_q <= '0;
         zero_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q <= acc_d;
         op_q <= op_d;
         rem_q <= rem_d;
         result_q <= result_d;
         zero_q <= zero_d;
      end
   end

   assign RESULT = result_q;
   assign ZERO = zero_q;
   assign BUSY = state_q == SHIFT;
   assign DONE = state_q == FIN;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed scoreboard bench for shift_sequencer at MAX_STEP=7 and MAX_STEP=1.
module tb_shift_sequencer;
   logic CLK = 1'b0, RESET = 1'b0, start0 = 1'b0, start1 = 1'b0;
   logic [1:0] OPCODE = '0;
   logic [7:0] DATA = '0, AMOUNT = '0, res0, res1;
   logic busy0, busy1, done0, done1, zero0, zero1;
   logic [8:0] sb[$];
   int checks = 0, errors = 0;

   shift_sequencer #(.MAX_STEP(7)) dut (.CLK(CLK), .RESET(RESET), .START(start0), .OPCODE(OPCODE), .DATA(DATA),
      .AMOUNT(AMOUNT), .RESULT(res0), .BUSY(busy0), .DONE(done0), .ZERO(zero0));
   shift_sequencer #(.MAX_STEP(1)) dut1 (.CLK(CLK), .RESET(RESET), .START(start1), .OPCODE(OPCODE), .DATA(DATA),
      .AMOUNT(AMOUNT), .RESULT(res1), .BUSY(busy1), .DONE(done1), .ZERO(zero1));

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // exp_p is the number of SHIFT passes; DONE is due exp_p+1 edges after START is raised
   task automatic run(input int u, input logic [1:0] op, input logic [7:0] d, input logic [7:0] a,
                      input logic [7:0] exp_r, input int exp_p, input bit repulse, input string tag);
      logic [8:0] exp;
      logic [7:0] prev;
      int busy_n, done_at;
      sb.push_back({exp_r == 8'h00, exp_r});
      prev = u == 1 ? res1 : res0;
      OPCODE = op;
      DATA = d;
      AMOUNT = a;
      start0 = u == 0;
      start1 = u == 1;
      busy_n = 0;
      done_at = 0;
      for (int c = 1; c <= 20 && done_at == 0; c++) begin
         @(posedge CLK);
         #1;
         start0 = u == 0 && repulse;
         start1 = 1'b0;
         if (repulse) DATA = 8'h00;
         if (u == 1 ? busy1 : busy0) begin
            busy_n++;
            chk({tag, "/hold"}, u == 1 ? res1 : res0, prev);
         end
         if (u == 1 ? done1 : done0) begin
            done_at = c;
            exp = sb.pop_front();
            chk({tag, "/result"}, u == 1 ? res1 : res0, exp[7:0]);
            chk({tag, "/zero"}, u == 1 ? zero1 : zero0, exp[8]);
         end
      end
      if (done_at == 0) sb.delete();
      chk({tag, "/latency"}, done_at, exp_p + 1);
      chk({tag, "/busy_cycles"}, busy_n, exp_p);
      @(posedge CLK);
      #1;
      start0 = 1'b0;
      chk({tag, "/single_done"}, u == 1 ? done1 : done0, 1'b0);
      @(posedge CLK);
      #1;
      chk({tag, "/idle_busy"}, u == 1 ? busy1 : busy0, 1'b0);
      chk({tag, "/idle_done"}, u == 1 ? done1 : done0, 1'b0);
   endtask

   initial begin
      int dones;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst/result", res0, 8'h00);
      chk("rst/busy", busy0, 1'b0);
      chk("rst/done", done0, 1'b0);
      chk("rst/zero", zero0, 1'b0);
      chk("rst/result1", res1, 8'h00);
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      run(0, 2'b00, 8'h01, 8'd3, 8'h08, 1, 1'b0, "sll3");
      run(0, 2'b10, 8'h80, 8'd200, 8'hFF, 2, 1'b0, "sra_neg");
      run(0, 2'b10, 8'h7F, 8'd200, 8'h00, 2, 1'b0, "sra_pos");
      run(0, 2'b11, 8'h81, 8'd9, 8'hC0, 1, 1'b0, "ror9");
      run(0, 2'b11, 8'h81, 8'd8, 8'h81, 0, 1'b0, "ror8");
      run(0, 2'b00, 8'hFF, 8'd8, 8'h00, 2, 1'b0, "sll8");
      run(0, 2'b11, 8'h01, 8'd7, 8'h02, 1, 1'b0, "ror7");
      run(0, 2'b10, 8'h80, 8'd0, 8'h80, 0, 1'b0, "sra0");
      run(0, 2'b00, 8'hA5, 8'd2, 8'h94, 1, 1'b1, "repulse");
      OPCODE = 2'b01;
      DATA = 8'hF0;
      AMOUNT = 8'd8;
      start0 = 1'b1;
      @(posedge CLK);
      #1;
      start0 = 1'b0;
      chk("abort/busy_before", busy0, 1'b1);
      #2;
      RESET = 1'b0;
      #1;
      chk("abort/result", res0, 8'h00);
      chk("abort/busy", busy0, 1'b0);
      chk("abort/done", done0, 1'b0);
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b1;
      dones = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge CLK);
         #1;
         if (done0 || busy0) dones++;
      end
      chk("abort/no_done", dones, 0);
      run(0, 2'b01, 8'hF0, 8'd4, 8'h0F, 1, 1'b0, "after_abort");
      run(1, 2'b00, 8'h01, 8'd7, 8'h80, 7, 1'b0, "step1_sll7");
      run(1, 2'b10, 8'h80, 8'd2, 8'hE0, 2, 1'b0, "step1_sra2");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
